// File: rtl/semimips_pkg.sv
// semimips_pkg: definitions shared by the semiMIPS pipeline control blocks.
//   DEFAULT_REGW    : register-index width
//   DEFAULT_TIMEOUT : default number of wait cycles before a data access is abandoned
//   ctrl_state_e    : hazard controller states
package semimips_pkg;

    localparam int unsigned DEFAULT_REGW    = 5;
    localparam int unsigned DEFAULT_TIMEOUT = 16;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/branch_eval.sv
// branch_eval: purely combinational branch/jump resolution from the MEM-stage
// controls and the ALU flags of the MEM-stage instruction.
// Ports:
//   bbne, bbeq, bblez, bbgtz, jump : branch/jump controls
//   zero, neg                      : ALU result == 0, ALU result sign bit
//   taken                          : 1 = redirect the PC to the branch/jump target
module branch_eval (
    input  logic bbne,
    input  logic bbeq,
    input  logic bblez,
    input  logic bbgtz,
    input  logic jump,
    input  logic zero,
    input  logic neg,
    output logic taken
);

    always_comb begin
        taken = (bbeq  & zero)
              | (bbne  & ~zero)
              | (bblez & (zero | neg))
              | (bbgtz & ~zero & ~neg)
              | jump;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and data-memory handshake controller for the
// semiMIPS five-stage core. Sole source of pipeline stalls and flushes.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   mem_memrd, mem_memwr          : MEM-stage load/store controls
//   mem_bb*, mem_jump             : MEM-stage branch/jump controls
//   mem_zero, mem_neg             : MEM-stage ALU flags
//   ex_memrd, ex_rt               : ID/EX load and its destination register
//   id_rs, id_rt, id_uses_rt      : ID-stage source registers and rt usage
//   mem_ack                       : data memory completes the access this cycle
//   mem_req                       : data memory request
//   pc_we .. exmem_we             : pipeline register write enables
//   ifid_flush .. memwb_flush     : synchronous zeroing at the next edge
//   pc_sel                        : 1 = load branch/jump target into the PC
//   bus_err                       : registered one-cycle pulse after a timeout
//   wait_cnt                      : registered wait-state count (debug)
module hazard_ctrl
    import semimips_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned REGW    = DEFAULT_REGW
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mem_memrd,
    input  logic                             mem_memwr,
    input  logic                             mem_bbne,
    input  logic                             mem_bbeq,
    input  logic                             mem_bblez,
    input  logic                             mem_bbgtz,
    input  logic                             mem_jump,
    input  logic                             mem_zero,
    input  logic                             mem_neg,
    input  logic                             ex_memrd,
    input  logic [REGW-1:0]                  ex_rt,
    input  logic [REGW-1:0]                  id_rs,
    input  logic [REGW-1:0]                  id_rt,
    input  logic                             id_uses_rt,
    input  logic                             mem_ack,
    output logic                             mem_req,
    output logic                             pc_we,
    output logic                             ifid_we,
    output logic                             idex_we,
    output logic                             exmem_we,
    output logic                             ifid_flush,
    output logic                             idex_flush,
    output logic                             exmem_flush,
    output logic                             memwb_flush,
    output logic                             pc_sel,
    output logic                             bus_err,
    output logic [$clog2(TIMEOUT+1)-1:0]     wait_cnt
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    ctrl_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;

    logic taken;
    logic lu;
    logic mem;
    logic stall;
    logic timeout;

    branch_eval u_branch_eval (
        .bbne  (mem_bbne),
        .bbeq  (mem_bbeq),
        .bblez (mem_bblez),
        .bbgtz (mem_bbgtz),
        .jump  (mem_jump),
        .zero  (mem_zero),
        .neg   (mem_neg),
        .taken (taken)
    );

    // Register 0 is hardwired, so a load into it never creates a dependency.
    always_comb begin
        lu = ex_memrd && (ex_rt != '0)
             && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    end

    always_comb begin
        mem     = mem_memrd | mem_memwr;
        timeout = (state_q == MEMWAIT) && !mem_ack && (cnt_q == CW'(TIMEOUT));
        // Memory stall covers the first un-acked cycle in RUN and every
        // un-acked MEMWAIT cycle, including the one that times out.
        stall   = ((state_q == RUN && mem) || state_q == MEMWAIT) && !mem_ack;

        mem_req     = 1'b0;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_sel      = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_err_d   = 1'b0;

        if (rst) begin
            // Enables stay high so the flushes clear every pipeline register.
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
        end else if (stall) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_we     = 1'b0;
            exmem_we    = 1'b0;
            memwb_flush = 1'b1;
            mem_req     = !timeout;
            if (timeout) begin
                // Abandon the access: drop the instruction held in EX/MEM.
                exmem_flush = 1'b1;
                bus_err_d   = 1'b1;
                state_d     = RUN;
                cnt_d       = '0;
            end else if (state_q == RUN) begin
                state_d = MEMWAIT;
                cnt_d   = CW'(1);
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            // Ack cycle (or no access): pipeline released, branch/load-use
            // hazards resolved as in a normal cycle.
            mem_req = mem || (state_q == MEMWAIT);
            state_d = RUN;
            cnt_d   = '0;
            if (taken) begin
                pc_sel      = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (lu) begin
                pc_we      = 1'b0;
                ifid_we    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        bus_err  = bus_err_q;
        wait_cnt = cnt_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned TO = 4;
    localparam int unsigned RW = 5;
    localparam int unsigned CW = $clog2(TO + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_memrd, mem_memwr;
    logic          mem_bbne, mem_bbeq, mem_bblez, mem_bbgtz, mem_jump;
    logic          mem_zero, mem_neg;
    logic          ex_memrd;
    logic [RW-1:0] ex_rt, id_rs, id_rt;
    logic          id_uses_rt;
    logic          mem_ack;
    logic          mem_req, pc_we, ifid_we, idex_we, exmem_we;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic          pc_sel, bus_err;
    logic [CW-1:0] wait_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .TIMEOUT (TO),
        .REGW    (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_memrd   (mem_memrd),
        .mem_memwr   (mem_memwr),
        .mem_bbne    (mem_bbne),
        .mem_bbeq    (mem_bbeq),
        .mem_bblez   (mem_bblez),
        .mem_bbgtz   (mem_bbgtz),
        .mem_jump    (mem_jump),
        .mem_zero    (mem_zero),
        .mem_neg     (mem_neg),
        .ex_memrd    (ex_memrd),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .pc_we       (pc_we),
        .ifid_we     (ifid_we),
        .idex_we     (idex_we),
        .exmem_we    (exmem_we),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .memwb_flush (memwb_flush),
        .pc_sel      (pc_sel),
        .bus_err     (bus_err),
        .wait_cnt    (wait_cnt)
    );

    typedef struct packed {
        logic          rst;
        logic          memrd;
        logic          memwr;
        logic          bbne;
        logic          bbeq;
        logic          bblez;
        logic          bbgtz;
        logic          jump;
        logic          zero;
        logic          neg;
        logic          ex_memrd;
        logic [RW-1:0] ex_rt;
        logic [RW-1:0] id_rs;
        logic [RW-1:0] id_rt;
        logic          uses_rt;
        logic          ack;
    } in_t;

    typedef struct {
        string       name;
        in_t         i;
        logic [13:0] exp;
    } vec_t;

    // {mem_req, pc/ifid/idex/exmem_we, ifid/idex/exmem/memwb_flush, pc_sel, bus_err, wait_cnt}
    logic [13:0] got;
    assign got = {mem_req, pc_we, ifid_we, idex_we, exmem_we,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush,
                  pc_sel, bus_err, wait_cnt};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: outstanding access, wait count, pending error pulse.
    bit m_wait = 1'b0;
    int m_cnt  = 0;
    bit m_err  = 1'b0;

    vec_t tbl[$];

    function automatic logic [13:0] ex(input logic req, input logic [3:0] we,
                                       input logic [3:0] fl, input logic sel,
                                       input logic err, input logic [2:0] cnt);
        return {req, we, fl, sel, err, cnt};
    endfunction

    function automatic logic [13:0] model_out(input in_t v);
        int         sgn;
        bit         tk, lu, mem;
        logic       req, sel;
        logic [3:0] we, fl;
        logic [2:0] c;
        mem = v.memrd || v.memwr;
        // Sign of the ALU result as -1/0/+1, branches compare it against zero.
        sgn = v.zero ? 0 : (v.neg ? -1 : 1);
        tk  = (v.bbeq && sgn == 0) || (v.bbne && sgn != 0) || (v.bblez && sgn <= 0)
              || (v.bbgtz && sgn > 0) || v.jump;
        lu  = v.ex_memrd && v.ex_rt != 0
              && (v.ex_rt == v.id_rs || (v.uses_rt && v.ex_rt == v.id_rt));
        req = 1'b0; we = 4'b1111; fl = 4'b0000; sel = 1'b0;
        if (v.rst) begin
            fl = 4'b1111;
        end else if (m_wait && !v.ack && m_cnt == TO) begin
            we = 4'b0000; fl = 4'b0011;
        end else if ((m_wait || mem) && !v.ack) begin
            req = 1'b1; we = 4'b0000; fl = 4'b0001;
        end else begin
            req = m_wait || mem;
            if (tk) begin
                sel = 1'b1; fl = 4'b1110;
            end else if (lu) begin
                we = 4'b0011; fl = 4'b0100;
            end
        end
        c = 3'(m_cnt);
        return ex(req, we, fl, sel, m_err, c);
    endfunction

    task automatic model_step(input in_t v);
        bit mem;
        mem = v.memrd || v.memwr;
        if (v.rst) begin
            m_wait = 1'b0; m_cnt = 0; m_err = 1'b0;
        end else begin
            m_err = m_wait && !v.ack && m_cnt == TO;
            if (m_wait) begin
                if (v.ack || m_cnt == TO) begin
                    m_wait = 1'b0; m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else if (mem && !v.ack) begin
                m_wait = 1'b1; m_cnt = 1;
            end
        end
    endtask

    task automatic drive(input in_t v);
        rst        = v.rst;
        mem_memrd  = v.memrd;
        mem_memwr  = v.memwr;
        mem_bbne   = v.bbne;
        mem_bbeq   = v.bbeq;
        mem_bblez  = v.bblez;
        mem_bbgtz  = v.bbgtz;
        mem_jump   = v.jump;
        mem_zero   = v.zero;
        mem_neg    = v.neg;
        ex_memrd   = v.ex_memrd;
        ex_rt      = v.ex_rt;
        id_rs      = v.id_rs;
        id_rt      = v.id_rt;
        id_uses_rt = v.uses_rt;
        mem_ack    = v.ack;
    endtask

    // Drive just after the rising edge, compare at the falling edge.
    task automatic run_cycle(input string name, input in_t v, input logic [13:0] exp,
                             input bit use_model);
        logic [13:0] e;
        drive(v);
        @(negedge clk);
        e = use_model ? model_out(v) : exp;
        n_tests++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL %s: got %b required %b (req we[4] fl[4] sel err cnt[3])",
                     name, got, e);
        end
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input string n, input in_t i, input logic [13:0] e);
        vec_t t;
        t.name = n; t.i = i; t.exp = e;
        tbl.push_back(t);
    endtask

    initial begin
        logic [13:0] o_norm, o_lu, o_tk, o_zw, o_rst;
        in_t idle, v;

        idle   = '0;
        o_norm = ex(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0);
        o_lu   = ex(1'b0, 4'b0011, 4'b0100, 1'b0, 1'b0, 3'd0);
        o_tk   = ex(1'b0, 4'b1111, 4'b1110, 1'b1, 1'b0, 3'd0);
        o_zw   = ex(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 3'd0);
        o_rst  = ex(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 3'd0);

        add("normal",       idle,                                                     o_norm);
        add("lu_rs",        in_t'{ex_memrd:1, ex_rt:5, id_rs:5, default:0},           o_lu);
        add("lu_resume",    idle,                                                     o_norm);
        add("lu_r0",        in_t'{ex_memrd:1, ex_rt:0, id_rs:0, default:0},           o_norm);
        add("lu_rt",        in_t'{ex_memrd:1, ex_rt:7, id_rt:7, id_rs:3, uses_rt:1,
                                  default:0},                                         o_lu);
        add("lu_rt_unused", in_t'{ex_memrd:1, ex_rt:7, id_rt:7, id_rs:3, default:0},  o_norm);
        add("no_load",      in_t'{ex_rt:5, id_rs:5, default:0},                       o_norm);
        add("beq_taken",    in_t'{bbeq:1, zero:1, default:0},                         o_tk);
        add("beq_not",      in_t'{bbeq:1, default:0},                                 o_norm);
        add("bne_taken",    in_t'{bbne:1, default:0},                                 o_tk);
        add("blez_neg",     in_t'{bblez:1, neg:1, default:0},                         o_tk);
        add("bgtz_neg",     in_t'{bbgtz:1, neg:1, default:0},                         o_norm);
        add("bgtz_pos",     in_t'{bbgtz:1, default:0},                                o_tk);
        add("jump",         in_t'{jump:1, default:0},                                 o_tk);
        add("taken_and_lu", in_t'{jump:1, ex_memrd:1, ex_rt:4, id_rs:4, default:0},   o_tk);
        add("zero_wait",    in_t'{memrd:1, ack:1, default:0},                         o_zw);
        add("stray_ack",    in_t'{ack:1, default:0},                                  o_norm);
        add("rst_flush",    in_t'{rst:1, memrd:1, jump:1, default:0},                 o_rst);

        // Power-on reset: registers are undefined until the first edge.
        v = '0; v.rst = 1'b1;
        drive(v);
        @(posedge clk);
        #1;
        model_step(v);
        run_cycle("reset", v, o_rst, 1'b0);

        foreach (tbl[k]) run_cycle(tbl[k].name, tbl[k].i, tbl[k].exp, 1'b0);

        // Three wait states, ack in the fourth cycle.
        v = in_t'{memwr:1, default:0};
        for (int c = 0; c < 3; c++)
            run_cycle("wait3_stall", v, ex(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 3'(c)), 1'b0);
        v.ack = 1'b1;
        run_cycle("wait3_ack", v, ex(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 3'd3), 1'b0);
        run_cycle("wait3_after", idle, o_norm, 1'b0);

        // Timeout: no ack at all.
        v = in_t'{memrd:1, default:0};
        for (int c = 0; c < 4; c++)
            run_cycle("to_stall", v, ex(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 3'(c)), 1'b0);
        run_cycle("to_abandon", v, ex(1'b0, 4'b0000, 4'b0011, 1'b0, 1'b0, 3'd4), 1'b0);
        v = in_t'{ack:1, default:0};
        run_cycle("to_err_pulse", v, ex(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 3'd0), 1'b0);
        run_cycle("to_err_once", idle, o_norm, 1'b0);

        // Reset in the middle of a wait.
        v = in_t'{memwr:1, default:0};
        run_cycle("rw_stall0", v, ex(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 3'd0), 1'b0);
        run_cycle("rw_stall1", v, ex(1'b1, 4'b0000, 4'b0001, 1'b0, 1'b0, 3'd1), 1'b0);
        v.rst = 1'b1;
        run_cycle("rw_rst_abort", v, ex(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0, 3'd2), 1'b0);
        run_cycle("rw_rst_held", v, o_rst, 1'b0);
        run_cycle("rw_resume", idle, o_norm, 1'b0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            v          = '0;
            v.rst      = ($urandom_range(0, 63) == 0);
            v.memrd    = ($urandom_range(0, 7) == 0);
            v.memwr    = ($urandom_range(0, 9) == 0);
            v.bbne     = ($urandom_range(0, 7) == 0);
            v.bbeq     = ($urandom_range(0, 7) == 0);
            v.bblez    = ($urandom_range(0, 7) == 0);
            v.bbgtz    = ($urandom_range(0, 7) == 0);
            v.jump     = ($urandom_range(0, 15) == 0);
            v.zero     = 1'($urandom_range(0, 1));
            v.neg      = 1'($urandom_range(0, 1));
            v.ex_memrd = 1'($urandom_range(0, 1));
            v.ex_rt    = RW'($urandom_range(0, 3));
            v.id_rs    = RW'($urandom_range(0, 3));
            v.id_rt    = RW'($urandom_range(0, 3));
            v.uses_rt  = 1'($urandom_range(0, 1));
            v.ack      = ($urandom_range(0, 2) == 0);
            run_cycle("random", v, '0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and memory-handshake controller for the semiMIPS five-stage core. It drives the enable and flush inputs of every pipeline register (IF/ID, ID/EX, EX/MEM control register, MEM/WB) and the PC write/select lines. Branches and jumps resolve in the MEM stage. It handles four cases: load-use stalls, taken-branch flushes, multi-cycle data-memory access with wait states, and access timeout. It is the only block allowed to assert pipeline flush or stall.

## Interface
Parameters:
- TIMEOUT, 16, maximum wait cycles for mem_ack before an access is abandoned (≥1)
- REGW, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- mem_memrd, mem_memwr  in  1 each  MEM-stage memory read/write control (EX/MEM register outputs)
- mem_bbne, mem_bbeq, mem_bblez, mem_bbgtz, mem_jump  in  1 each  MEM-stage branch/jump controls
- mem_zero, mem_neg  in  1 each  ALU result flags of the MEM-stage instruction (==0, sign bit)
- ex_memrd  in  1  ID/EX-stage instruction is a load
- ex_rt  in  REGW  load destination register
- id_rs, id_rt  in  REGW  source registers of the ID-stage instruction
- id_uses_rt  in  1  ID-stage instruction reads rt
- mem_ack  in  1  data memory completes the current access this cycle
- mem_req  out  1  data memory access request
- pc_we, ifid_we, idex_we, exmem_we  out  1 each  register write enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  synchronous zeroing of the register at the next edge
- pc_sel  out  1  1 = load the branch/jump target into the PC
- bus_err  out  1  one-cycle pulse when an access times out
- wait_cnt  out  $clog2(TIMEOUT+1)  current wait-state count, for debug

## Operation
- Controller states: RUN, MEMWAIT.
- Combinational taken signal:
  - taken = (bbeq&zero) | (bbne&~zero) | (bblez&(zero|neg)) | (bbgtz&~zero&~neg) | jump
- Load-use hazard:
  - lu = ex_memrd & (ex_rt≠0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt))
- In RUN, with mem = mem_memrd|mem_memwr:
  - **mem & ~mem_ack:**
    - mem_req=1
    - all *_we=0
    - memwb_flush=1
    - wait_cnt←1
    - next state MEMWAIT
  - **mem & mem_ack:** zero-wait access; mem_req=1; no stall.
  - **taken:**
    - pc_sel=1
    - ifid_flush=idex_flush=exmem_flush=1
    - all *_we=1
  - **lu (no taken):**
    - pc_we=ifid_we=0
    - idex_flush=1
  - **Otherwise:** all *_we=1, all flushes=0.
- Priority: memory stall > taken > lu.
  - taken and lu in the same cycle: flush only; no stall.
  - mem and taken are mutually exclusive by ISA encoding. If both are asserted, mem wins and taken is re-evaluated after the stall.
- In MEMWAIT:
  - mem_req=1, all *_we=0, memwb_flush=1.
  - On mem_ack: release all controls in that cycle (all *_we=1, memwb_flush=0), wait_cnt←0, next state RUN.
  - On wait_cnt==TIMEOUT without ack:
    - bus_err=1 for one cycle
    - exmem_flush=1 (abandons the access)
    - mem_req=0
    - next state RUN
  - Otherwise wait_cnt increments.
- **Reset:**
  - State RUN, wait_cnt=0, bus_err=0, mem_req=0, pc_sel=0.
  - While rst=1, all four *_flush=1 and all *_we=1, so the un-reset pipeline registers clear.

## Timing
- Control outputs are Mealy-combinational from state and inputs. Zero-cycle latency to the register enables. Registers update at the following edge.
- bus_err and wait_cnt are registered.
- Load-use stall lasts exactly one cycle. lu deasserts once the load moves to MEM.
- Taken branch: 3 bubbles (IF/ID, ID/EX, EX/MEM). The target is fetched the cycle after pc_sel.
- A memory access with N wait cycles stalls the pipeline N cycles. mem_req stays continuously high from the first cycle until the ack cycle inclusive.
- mem_ack while mem_req=0 is ignored.
- rst asserted in MEMWAIT aborts the access: mem_req drops in the same cycle and no bus_err is raised.

## Structure
- Shared package semimips_pkg:
  - state enum {RUN, MEMWAIT}
  - REGW
  - default TIMEOUT
- Sub-module branch_eval: purely combinational taken computation. It is reused by the branch target unit.

## Test plan
- **Load-use:** ex_memrd=1, ex_rt=5, id_rs=5 → one cycle with pc_we=ifid_we=0, idex_flush=1. Normal operation resumes next cycle. Repeat with ex_rt=0 → no stall.
- **Taken branch:** mem_bbeq=1, mem_zero=1 → pc_sel=1 and the three flushes asserted for one cycle. Repeat with mem_bblez=1, mem_neg=1, zero=0 → taken. Repeat with mem_bbgtz=1, neg=1 → not taken.
- **Zero-wait access:** mem_memrd=1, mem_ack=1 in the same cycle → mem_req=1, no stall, state stays RUN.
- **Three-wait access:** mem_memwr=1, ack on the 4th cycle → 3 cycles with all *_we=0, memwb_flush=1, wait_cnt 1,2,3. Release in the ack cycle.
- **Timeout:** TIMEOUT=4, no ack → bus_err pulses exactly once when wait_cnt=4, exmem_flush=1, state returns to RUN, mem_req=0 the next cycle.
- **Reset mid-wait:** rst=1 during the 2nd wait cycle → next cycle state RUN, wait_cnt=0, mem_req=0, bus_err=0. All flushes stay high while rst is held.
